// File: rtl/lut_func_engine.sv
// lut_func_engine: programmable N_IN-input boolean function unit.
// The function lives in a 2**N_IN-bit truth table; bit i holds f(vec == i).
// Vectors flow through a two-stage valid/ready pipeline. The table is reloaded
// through a chunked config handshake into a shadow copy, then committed in one cycle.
// Optional feature macro: LUT_HIT_COUNT_EN enables the saturating hit counter;
// without it hit_count is tied to zero.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no load in progress; cfg_valid ignored
// ST_LOAD   | collecting beats into shadow, lowest chunk first
// ST_COMMIT | one cycle: shadow copied to active table, cfg_done pulsed

module lut_func_engine #(
    parameter int                      N_IN        = 4,
    parameter int                      CFG_W       = 8,
    parameter logic [(2**N_IN)-1:0]    RESET_TABLE = 16'hAA45,
    parameter int                      CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_f,
    output logic [N_IN-1:0]  out_vec,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic [CNT_W-1:0] hit_count
);

    localparam int TABLE_W = 2**N_IN;
    localparam int BEATS   = TABLE_W / CFG_W;
    localparam int K_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } cfg_state_e;

    cfg_state_e                    state_q, state_d;
    logic [K_W-1:0]                k_q, k_d;
    logic [BEATS-1:0][CFG_W-1:0]   shadow_q, shadow_d;
    logic [TABLE_W-1:0]            active_q, active_d;

    logic                          s1_valid_q, s1_valid_d;
    logic [N_IN-1:0]               s1_vec_q, s1_vec_d;
    logic                          out_valid_q, out_valid_d;
    logic [N_IN-1:0]               out_vec_q, out_vec_d;
    logic                          out_f_q, out_f_d;
    logic                          adv;

    // Pipeline advance: both stages move together whenever the output slot frees up.
    // The lookup uses the active table of the advancing cycle, so a commit edge
    // still evaluates with the old table.
    always_comb begin
        adv         = ~out_valid_q | out_ready;
        s1_valid_d  = s1_valid_q;
        s1_vec_d    = s1_vec_q;
        out_valid_d = out_valid_q;
        out_vec_d   = out_vec_q;
        out_f_d     = out_f_q;
        if (adv) begin
            s1_valid_d  = in_valid;
            if (in_valid) begin
                s1_vec_d = in_vec;
            end
            out_valid_d = s1_valid_q;
            out_vec_d   = s1_vec_q;
            out_f_d     = active_q[s1_vec_q];
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_vec_q    <= '0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_f_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_vec_q    <= s1_vec_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            out_f_q     <= out_f_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;
    assign out_f     = out_f_q;

    // Config FSM next-state and outputs. A start in LOAD restarts at chunk 0 and
    // drops any beat presented alongside it; a start in COMMIT is ignored.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        cfg_ready = 1'b0;
        cfg_busy  = 1'b0;
        cfg_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    k_d     = '0;
                end
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
                cfg_busy  = 1'b1;
                if (cfg_start) begin
                    k_d = '0;
                end else if (cfg_valid) begin
                    shadow_d[k_q] = cfg_data;
                    if (k_q == K_W'(BEATS - 1)) begin
                        state_d = ST_COMMIT;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                cfg_busy = 1'b1;
                cfg_done = 1'b1;
                active_d = shadow_q;
                k_d      = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Config state, beat index, shadow and active tables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            shadow_q <= '0;
            active_q <= RESET_TABLE;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

`ifdef LUT_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_q, hit_d;

    // Hit counter: saturating count of delivered ones; a commit clears it and
    // takes priority over a simultaneous hit.
    always_comb begin
        hit_d = hit_q;
        if (state_q == ST_COMMIT) begin
            hit_d = '0;
        end else if (out_valid_q && out_ready && out_f_q && !(&hit_q)) begin
            hit_d = hit_q + CNT_W'(1);
        end
    end

    // Hit counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_count = hit_q;
`else
    assign hit_count = '0;
`endif

endmodule
